// File: rtl/clock_set_controller_pkg.sv
// Shared definitions for the clock set controller: FSM state encoding,
// edit-field codes, field limits, button indices and the seed clamp helper.
package clock_set_controller_pkg;

  typedef enum logic [3:0] {
    ST_RUN,
    ST_T_HR, ST_T_MIN, ST_T_SEC,
    ST_LD_T_HR, ST_LD_T_MIN, ST_LD_T_SEC,
    ST_A_HR, ST_A_MIN, ST_A_SEC,
    ST_LD_A_HR, ST_LD_A_MIN, ST_LD_A_SEC
  } state_t;

  localparam logic [1:0] FLD_HR   = 2'd0;
  localparam logic [1:0] FLD_MIN  = 2'd1;
  localparam logic [1:0] FLD_SEC  = 2'd2;
  localparam logic [1:0] FLD_NONE = 2'd3;

  localparam int HR_MAX_DEF  = 23;
  localparam int MS_MAX_DEF  = 59;
  localparam int TIMEOUT_DEF = 10_000_000;

  // Button lanes, in the order they are packed into the edge detector array.
  localparam int NUM_BTN   = 4;
  localparam int BTN_MODE  = 0;
  localparam int BTN_ALARM = 1;
  localparam int BTN_UP    = 2;
  localparam int BTN_NEXT  = 3;

  // A seed value that cannot be displayed in the field restarts the edit at 0.
  function automatic logic [5:0] seed_val(input logic [5:0] v, input logic [5:0] max);
    return (v > max) ? 6'd0 : v;
  endfunction

endpackage

// File: rtl/clock_set_controller_button_edge_detect.sv
// Registered rising-edge detector for one debounced push-button.
//   clk, reset : system clock, synchronous active-high reset (clears history)
//   btn        : debounced button level
//   press      : high for the cycle in which btn is high and was low last cycle
module button_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);

  logic btn_q;

  always_ff @(posedge clk) begin
    if (reset) btn_q <= 1'b0;
    else       btn_q <= btn;
  end

  assign press = btn & ~btn_q;

endmodule

// File: rtl/clock_set_controller.sv
// Button-driven sequencer for the digital clock datapath: time set, alarm set,
// alarm arm toggle and alarm stop.
//   clk, reset                 : system clock, synchronous active-high reset
//   btn_mode/alarm/up/next     : debounced button levels
//   cur_hr/cur_min/cur_sec     : live time, seeds time edits
//   alarm_detector             : alarm is ringing
//   input_data                 : shared load bus (current edit value)
//   ld_hr/min/sec              : one-cycle time load strobes
//   ld_alarm_hr/min/sec        : one-cycle alarm load strobes
//   on                         : clock run enable (low while setting time)
//   on_alarm                   : alarm armed
//   stop_alarm                 : one-cycle alarm stop pulse
//   edit_active, edit_field    : edit indication for the display (3 = none)
module clock_set_controller
  import clock_set_controller_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_DEF,
  parameter int HR_MAX      = HR_MAX_DEF,
  parameter int MS_MAX      = MS_MAX_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_alarm,
  input  logic       btn_up,
  input  logic       btn_next,
  input  logic [5:0] cur_hr,
  input  logic [5:0] cur_min,
  input  logic [5:0] cur_sec,
  input  logic       alarm_detector,
  output logic [5:0] input_data,
  output logic       ld_hr,
  output logic       ld_min,
  output logic       ld_sec,
  output logic       ld_alarm_hr,
  output logic       ld_alarm_min,
  output logic       ld_alarm_sec,
  output logic       on,
  output logic       on_alarm,
  output logic       stop_alarm,
  output logic       edit_active,
  output logic [1:0] edit_field
);

  localparam int             TW       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [5:0]     HMAX     = 6'(HR_MAX);
  localparam logic [5:0]     MMAX     = 6'(MS_MAX);

  // ---------------- button edges ----------------
  logic [NUM_BTN-1:0] btn_lvl, press;

  assign btn_lvl = {btn_next, btn_up, btn_alarm, btn_mode};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    button_edge_detect u_edge (
      .clk   (clk),
      .reset (reset),
      .btn   (btn_lvl[i]),
      .press (press[i])
    );
  end

  // Single winning press: mode > alarm > next > up. While the alarm rings
  // every press is spent on stopping it instead.
  logic any_press, act, p_mode, p_alarm, p_next, p_up;

  always_comb begin
    any_press = |press;
    act       = ~alarm_detector;
    p_mode    = act & press[BTN_MODE];
    p_alarm   = act & press[BTN_ALARM] & ~press[BTN_MODE];
    p_next    = act & press[BTN_NEXT]  & ~press[BTN_MODE] & ~press[BTN_ALARM];
    p_up      = act & press[BTN_UP]    & ~press[BTN_MODE] & ~press[BTN_ALARM]
                    & ~press[BTN_NEXT];
  end

  // ---------------- state ----------------
  state_t        state_q, state_d;
  logic [5:0]    edit_q, edit_d;
  logic [5:0]    alm_hr_q, alm_min_q, alm_sec_q;
  logic          on_alarm_q, on_alarm_d;
  logic          stop_alarm_q;
  logic [TW-1:0] tmo_q, tmo_d;

  logic       is_edit, hr_field;
  logic [5:0] edit_max, edit_inc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_RUN;
      edit_q       <= '0;
      alm_hr_q     <= '0;
      alm_min_q    <= '0;
      alm_sec_q    <= '0;
      on_alarm_q   <= 1'b0;
      stop_alarm_q <= 1'b0;
      tmo_q        <= '0;
    end else begin
      state_q      <= state_d;
      edit_q       <= edit_d;
      on_alarm_q   <= on_alarm_d;
      stop_alarm_q <= alarm_detector & any_press;
      tmo_q        <= tmo_d;
      if (state_q == ST_LD_A_HR)  alm_hr_q  <= edit_q;
      if (state_q == ST_LD_A_MIN) alm_min_q <= edit_q;
      if (state_q == ST_LD_A_SEC) alm_sec_q <= edit_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    edit_d     = edit_q;
    on_alarm_d = on_alarm_q;

    is_edit  = (state_q inside {ST_T_HR, ST_T_MIN, ST_T_SEC, ST_A_HR, ST_A_MIN, ST_A_SEC});
    hr_field = (state_q inside {ST_T_HR, ST_A_HR});
    edit_max = hr_field ? HMAX : MMAX;
    edit_inc = (edit_q >= edit_max) ? 6'd0 : edit_q + 6'd1;

    case (state_q)
      ST_RUN: begin
        if (p_mode) begin
          state_d = ST_T_HR;
          edit_d  = seed_val(cur_hr, HMAX);
        end else if (p_alarm) begin
          state_d = ST_A_HR;
          edit_d  = seed_val(alm_hr_q, HMAX);
        end else if (p_up) begin
          on_alarm_d = ~on_alarm_q;
        end
      end
      ST_T_HR, ST_T_MIN, ST_T_SEC, ST_A_HR, ST_A_MIN, ST_A_SEC: begin
        if (p_mode) begin
          state_d = ST_RUN;
        end else if (p_next) begin
          case (state_q)
            ST_T_HR:  state_d = ST_LD_T_HR;
            ST_T_MIN: state_d = ST_LD_T_MIN;
            ST_T_SEC: state_d = ST_LD_T_SEC;
            ST_A_HR:  state_d = ST_LD_A_HR;
            ST_A_MIN: state_d = ST_LD_A_MIN;
            default:  state_d = ST_LD_A_SEC;
          endcase
        end else if (p_up) begin
          edit_d = edit_inc;
        end else if (!any_press && tmo_q == TMO_LAST) begin
          // Abandoned edit: fields already committed stay committed.
          state_d = ST_RUN;
        end
      end
      // Load states last one cycle and pre-seed the next field.
      ST_LD_T_HR: begin
        state_d = ST_T_MIN;
        edit_d  = seed_val(cur_min, MMAX);
      end
      ST_LD_T_MIN: begin
        state_d = ST_T_SEC;
        edit_d  = seed_val(cur_sec, MMAX);
      end
      ST_LD_A_HR: begin
        state_d = ST_A_MIN;
        edit_d  = seed_val(alm_min_q, MMAX);
      end
      ST_LD_A_MIN: begin
        state_d = ST_A_SEC;
        edit_d  = seed_val(alm_sec_q, MMAX);
      end
      ST_LD_T_SEC, ST_LD_A_SEC: state_d = ST_RUN;
      default:                  state_d = ST_RUN;
    endcase

    // Idle counter only runs while parked in an edit state.
    if (any_press || state_d != state_q || !is_edit) tmo_d = '0;
    else                                             tmo_d = tmo_q + TW'(1);
  end

  // ---------------- outputs (registers / state decode only) ----------------
  always_comb begin
    input_data   = edit_q;
    ld_hr        = (state_q == ST_LD_T_HR);
    ld_min       = (state_q == ST_LD_T_MIN);
    ld_sec       = (state_q == ST_LD_T_SEC);
    ld_alarm_hr  = (state_q == ST_LD_A_HR);
    ld_alarm_min = (state_q == ST_LD_A_MIN);
    ld_alarm_sec = (state_q == ST_LD_A_SEC);
    on           = !(state_q inside {ST_T_HR, ST_T_MIN, ST_T_SEC,
                                     ST_LD_T_HR, ST_LD_T_MIN, ST_LD_T_SEC});
    on_alarm     = on_alarm_q;
    stop_alarm   = stop_alarm_q;
    edit_active  = (state_q != ST_RUN);
    case (state_q)
      ST_T_HR,  ST_LD_T_HR,  ST_A_HR,  ST_LD_A_HR:  edit_field = FLD_HR;
      ST_T_MIN, ST_LD_T_MIN, ST_A_MIN, ST_LD_A_MIN: edit_field = FLD_MIN;
      ST_T_SEC, ST_LD_T_SEC, ST_A_SEC, ST_LD_A_SEC: edit_field = FLD_SEC;
      default:                                      edit_field = FLD_NONE;
    endcase
  end

endmodule
